// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: three-stage signed pre-add / multiply / accumulate slice with
// valid-ready flow control, saturating or wrapping output and sticky overflow.
module dsp_mac_pipe #(
   parameter int A_WIDTH   = 18,
   parameter int B_WIDTH   = 18,
   parameter int ACC_WIDTH = 48,
   parameter bit SATURATE  = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [A_WIDTH-1:0]   i_a,
   input  logic [B_WIDTH-1:0]   i_b,
   input  logic [B_WIDTH-1:0]   i_d,
   input  logic [ACC_WIDTH-1:0] i_c,
   input  logic [1:0]           i_presel,
   input  logic [1:0]           i_op,
   input  logic                 i_clr,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [ACC_WIDTH-1:0] o_p,
   output logic                 o_ovf
);
   localparam int M_WIDTH = A_WIDTH + B_WIDTH + 1;

   logic                 w_adv;
   logic                 r_v1, r_v2, r_out_valid, r_ovf, r_clr, r_clr2;
   logic [A_WIDTH-1:0]   r_a;
   logic [B_WIDTH-1:0]   r_b, r_d;
   logic [ACC_WIDTH-1:0] r_c, r_c2, r_p;
   logic [1:0]           r_presel, r_op, r_op2;
   logic [M_WIDTH-1:0]   r_m, w_m;
   logic [B_WIDTH:0]     w_bx, w_dx, w_pre;
   logic [ACC_WIDTH:0]   w_mx, w_cx, w_accx, w_sum, w_sat;
   logic [ACC_WIDTH-1:0] w_p;
   logic                 w_ovf;

   assign w_adv       = !r_out_valid | i_out_ready;
   assign o_in_ready  = w_adv;
   assign o_out_valid = r_out_valid;
   assign o_p         = r_p;
   assign o_ovf       = r_ovf;

   assign w_bx  = {r_b[B_WIDTH-1], r_b};
   assign w_dx  = {r_d[B_WIDTH-1], r_d};
   assign w_pre = (r_presel == 2'b00) ? w_bx :
                  (r_presel == 2'b01) ? w_dx + w_bx :
                  (r_presel == 2'b10) ? w_dx - w_bx : '0;
   // both operands sign-extended to the product width, so the low bits of an unsigned multiply are the signed product
   assign w_m = {{(B_WIDTH+1){r_a[A_WIDTH-1]}}, r_a} * {{A_WIDTH{w_pre[B_WIDTH]}}, w_pre};

   assign w_mx   = {{(ACC_WIDTH+1-M_WIDTH){r_m[M_WIDTH-1]}}, r_m};
   assign w_cx   = {r_c2[ACC_WIDTH-1], r_c2};
   assign w_accx = r_clr2 ? '0 : {r_p[ACC_WIDTH-1], r_p};
   assign w_sum  = (r_op2 == 2'b00) ? w_mx + w_cx :
                   (r_op2 == 2'b01) ? w_accx + w_mx :
                   (r_op2 == 2'b10) ? w_accx - w_mx : w_cx - w_mx;
   assign w_ovf  = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
   // top bit of the wide sum is the true sign, selecting the clamp direction
   assign w_sat  = {w_sum[ACC_WIDTH], w_sum[ACC_WIDTH], {(ACC_WIDTH-1){~w_sum[ACC_WIDTH]}}};
   assign w_p    = (SATURATE && w_ovf) ? w_sat[ACC_WIDTH-1:0] : w_sum[ACC_WIDTH-1:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v1        <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_d         <= '0;
         r_c         <= '0;
         r_presel    <= '0;
         r_op        <= '0;
         r_clr       <= 1'b0;
         r_v2        <= 1'b0;
         r_m         <= '0;
         r_c2        <= '0;
         r_op2       <= '0;
         r_clr2      <= 1'b0;
         r_out_valid <= 1'b0;
         r_p         <= '0;
         r_ovf       <= 1'b0;
      end else if (w_adv) begin
         r_v1        <= i_in_valid;
         r_a         <= i_a;
         r_b         <= i_b;
         r_d         <= i_d;
         r_c         <= i_c;
         r_presel    <= i_presel;
         r_op        <= i_op;
         r_clr       <= i_clr;
         r_v2        <= r_v1;
         r_m         <= w_m;
         r_c2        <= r_c;
         r_op2       <= r_op;
         r_clr2      <= r_clr;
         r_out_valid <= r_v2;
         if (r_v2) begin
            r_p   <= w_p;
            r_ovf <= r_ovf | w_ovf;
         end
      end
   end
endmodule
